// File: rtl/volley_pkg.sv
// Shared types and the set-closure rule for the volleyball match controller.
package volley_pkg;

  typedef enum logic {TEAM_A = 1'b0, TEAM_B = 1'b1} team_t;
  typedef enum logic {PLAY = 1'b0, OVER = 1'b1} state_t;

  // new_x is the scorer's post-increment score; the lead test never underflows.
  function automatic logic set_closed(input int unsigned new_x, input int unsigned other,
                                      input int unsigned target, input int unsigned margin);
    return (new_x >= target) && (new_x >= other) && ((new_x - other) >= margin);
  endfunction

endpackage

// File: rtl/set_history_buf.sv
// Final score of each completed set: one write port, asynchronous read port.
module set_history_buf #(
  parameter int unsigned DEPTH = 5,
  parameter int unsigned AW    = 3,
  parameter int unsigned DW    = 7
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_a_i,
  input  logic [DW-1:0] wdata_b_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_a_o,
  output logic [DW-1:0] rdata_b_o
);

  logic [DW-1:0] mem_a_q [DEPTH];
  logic [DW-1:0] mem_b_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_a_q[waddr_i] <= wdata_a_i;
      mem_b_q[waddr_i] <= wdata_b_i;
    end
  end

  // Indices past the last set read as zero instead of an undefined entry.
  assign rdata_a_o = (32'(raddr_i) < DEPTH) ? mem_a_q[raddr_i] : '0;
  assign rdata_b_o = (32'(raddr_i) < DEPTH) ? mem_b_q[raddr_i] : '0;

endmodule

// File: rtl/volley_match_ctrl.sv
// Volleyball match controller: rally scoring, win-by-margin set closure, sets,
// serve possession, one-level undo and per-set score history.
module volley_match_ctrl
  import volley_pkg::*;
#(
  parameter int unsigned SETS_TO_WIN    = 3,
  parameter int unsigned SET_POINTS     = 25,
  parameter int unsigned DECIDER_POINTS = 15,
  parameter int unsigned WIN_MARGIN     = 2,
  parameter int unsigned SCORE_W        = 7,
  parameter int unsigned SET_W          = 3
) (
  input  logic               iCLK,
  input  logic               iRST_N,
  input  logic               point_a,
  input  logic               point_b,
  input  logic               undo,
  input  logic               new_match,
  input  logic [SET_W-1:0]   hist_idx,
  output logic [SCORE_W-1:0] score_a,
  output logic [SCORE_W-1:0] score_b,
  output logic [SET_W-1:0]   sets_a,
  output logic [SET_W-1:0]   sets_b,
  output logic [SET_W-1:0]   set_no,
  output logic               server,
  output logic               set_done,
  output logic               match_over,
  output logic               winner,
  output logic [SCORE_W-1:0] hist_a,
  output logic [SCORE_W-1:0] hist_b,
  output logic               hist_vld,
  output logic               err
);

  localparam int unsigned NSETS = 2 * SETS_TO_WIN - 1;

  state_t             state_q;
  logic [SCORE_W-1:0] score_a_q, score_b_q;
  logic [SET_W-1:0]   sets_a_q, sets_b_q, set_no_q, hist_cnt_q;
  logic               server_q, set_done_q, match_over_q, winner_q, err_q, undo_vld_q;
  team_t              last_scorer_q;

  team_t              scorer;
  logic [SCORE_W-1:0] cur_x, cur_o, score_x_d, wdata_a, wdata_b;
  logic [SET_W-1:0]   sets_x;
  logic               sat, closes, match_won, hist_we;
  int unsigned        target;

  assign scorer    = point_b ? TEAM_B : TEAM_A;
  assign cur_x     = point_b ? score_b_q : score_a_q;
  assign cur_o     = point_b ? score_a_q : score_b_q;
  assign sets_x    = point_b ? sets_b_q : sets_a_q;
  assign sat       = &cur_x;
  assign score_x_d = cur_x + SCORE_W'(1);
  assign target    = (set_no_q == SET_W'(NSETS)) ? DECIDER_POINTS : SET_POINTS;
  // Widened compare so the post-increment score is judged before any wrap.
  assign closes    = set_closed(32'(cur_x) + 32'd1, 32'(cur_o), target, WIN_MARGIN);
  assign match_won = (32'(sets_x) + 32'd1) == SETS_TO_WIN;

  assign hist_we = (state_q == PLAY) && !new_match && !undo && (point_a ^ point_b)
                   && !sat && closes;
  assign wdata_a = point_b ? score_a_q : score_x_d;
  assign wdata_b = point_b ? score_x_d : score_b_q;

  set_history_buf #(.DEPTH(NSETS), .AW(SET_W), .DW(SCORE_W)) u_hist (
    .clk_i     (iCLK),
    .we_i      (hist_we),
    .waddr_i   (set_no_q - SET_W'(1)),
    .wdata_a_i (wdata_a),
    .wdata_b_i (wdata_b),
    .raddr_i   (hist_idx),
    .rdata_a_o (hist_a),
    .rdata_b_o (hist_b)
  );

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q <= PLAY;       score_a_q <= '0;     score_b_q <= '0;
      sets_a_q <= '0;        sets_b_q <= '0;      set_no_q <= SET_W'(1);
      hist_cnt_q <= '0;      server_q <= 1'b0;    set_done_q <= 1'b0;
      match_over_q <= 1'b0;  winner_q <= 1'b0;    err_q <= 1'b0;
      undo_vld_q <= 1'b0;    last_scorer_q <= TEAM_A;
    end else if (new_match) begin
      state_q <= PLAY;       score_a_q <= '0;     score_b_q <= '0;
      sets_a_q <= '0;        sets_b_q <= '0;      set_no_q <= SET_W'(1);
      hist_cnt_q <= '0;      server_q <= 1'b0;    set_done_q <= 1'b0;
      match_over_q <= 1'b0;  winner_q <= 1'b0;    err_q <= 1'b0;
      undo_vld_q <= 1'b0;    last_scorer_q <= TEAM_A;
    end else begin
      set_done_q <= 1'b0;
      err_q      <= 1'b0;
      if (state_q == OVER) begin
        err_q <= point_a | point_b | undo;
      end else if (undo) begin
        if (undo_vld_q) begin
          if (last_scorer_q == TEAM_A) score_a_q <= score_a_q - SCORE_W'(1);
          else                         score_b_q <= score_b_q - SCORE_W'(1);
          undo_vld_q <= 1'b0;
        end else begin
          err_q <= 1'b1;
        end
      end else if (point_a && point_b) begin
        err_q <= 1'b1;
      end else if (point_a || point_b) begin
        if (sat) begin
          err_q <= 1'b1;
        end else if (closes) begin
          hist_cnt_q <= hist_cnt_q + SET_W'(1);
          score_a_q  <= '0;
          score_b_q  <= '0;
          undo_vld_q <= 1'b0;
          set_done_q <= 1'b1;
          server_q   <= set_no_q[0];
          if (scorer == TEAM_A) sets_a_q <= sets_a_q + SET_W'(1);
          else                  sets_b_q <= sets_b_q + SET_W'(1);
          if (match_won) begin
            state_q      <= OVER;
            match_over_q <= 1'b1;
            winner_q     <= (scorer == TEAM_B);
          end else begin
            set_no_q <= set_no_q + SET_W'(1);
          end
        end else begin
          if (scorer == TEAM_A) score_a_q <= score_x_d;
          else                  score_b_q <= score_x_d;
          server_q      <= (scorer == TEAM_B);
          last_scorer_q <= scorer;
          undo_vld_q    <= 1'b1;
        end
      end
    end
  end

  assign score_a    = score_a_q;
  assign score_b    = score_b_q;
  assign sets_a     = sets_a_q;
  assign sets_b     = sets_b_q;
  assign set_no     = set_no_q;
  assign server     = server_q;
  assign set_done   = set_done_q;
  assign match_over = match_over_q;
  assign winner     = winner_q;
  assign err        = err_q;
  assign hist_vld   = hist_idx < hist_cnt_q;

endmodule

// File: tb/tb_volley_match_ctrl.sv
// Randomised and directed bench for volley_match_ctrl against a rule-level match model.
module tb_volley_match_ctrl;

  localparam int STW = 3, SP = 25, DP = 15, MG = 2, SMAX = 127;

  logic       iCLK = 1'b0, iRST_N = 1'b0;
  logic       point_a = 0, point_b = 0, undo = 0, new_match = 0;
  logic [2:0] hist_idx = 3'd0;
  logic [6:0] score_a, score_b, hist_a, hist_b;
  logic [2:0] sets_a, sets_b, set_no;
  logic       server, set_done, match_over, winner, hist_vld, err;

  logic       s_rst_n = 1'b0, s_pa = 0, s_pb = 0, s_undo = 0, s_nm = 0;
  logic [2:0] s_hidx = 3'd0;
  logic [2:0] s_score_a, s_score_b, s_hist_a, s_hist_b, s_sets_a, s_sets_b, s_set_no;
  logic       s_server, s_set_done, s_match_over, s_winner, s_hist_vld, s_err;

  volley_match_ctrl dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .point_a(point_a), .point_b(point_b), .undo(undo),
    .new_match(new_match), .hist_idx(hist_idx), .score_a(score_a), .score_b(score_b),
    .sets_a(sets_a), .sets_b(sets_b), .set_no(set_no), .server(server),
    .set_done(set_done), .match_over(match_over), .winner(winner), .hist_a(hist_a),
    .hist_b(hist_b), .hist_vld(hist_vld), .err(err)
  );

  volley_match_ctrl #(.SCORE_W(3)) dut_sat (
    .iCLK(iCLK), .iRST_N(s_rst_n), .point_a(s_pa), .point_b(s_pb), .undo(s_undo),
    .new_match(s_nm), .hist_idx(s_hidx), .score_a(s_score_a), .score_b(s_score_b),
    .sets_a(s_sets_a), .sets_b(s_sets_b), .set_no(s_set_no), .server(s_server),
    .set_done(s_set_done), .match_over(s_match_over), .winner(s_winner),
    .hist_a(s_hist_a), .hist_b(s_hist_b), .hist_vld(s_hist_vld), .err(s_err)
  );

  always #5 iCLK = ~iCLK;

  int n_checks = 0, n_pass = 0, n_txn = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // Reference model: the match as a scorekeeper would keep it.
  int m_score[2], m_sets[2], m_ha[8], m_hb[8];
  int m_setno, m_server, m_over, m_winner, m_last, m_uvld, m_done, m_err, m_nhist;

  function automatic void model_clear();
    m_score[0] = 0; m_score[1] = 0; m_sets[0] = 0; m_sets[1] = 0;
    m_setno = 1; m_server = 0; m_over = 0; m_winner = 0; m_last = 0;
    m_uvld = 0; m_done = 0; m_err = 0; m_nhist = 0;
  endfunction

  function automatic void model_step(input bit pa, input bit pb, input bit un, input bit nm);
    int t, ns, tgt;
    m_done = 0; m_err = 0;
    if (nm) begin
      model_clear();
    end else if (m_over != 0) begin
      m_err = (pa || pb || un) ? 1 : 0;
    end else if (un) begin
      if (m_uvld != 0) begin m_score[m_last] -= 1; m_uvld = 0; end
      else m_err = 1;
    end else if (pa && pb) begin
      m_err = 1;
    end else if (pa || pb) begin
      t = pb ? 1 : 0;
      if (m_score[t] == SMAX) begin
        m_err = 1;
      end else begin
        ns  = m_score[t] + 1;
        tgt = (m_setno == 2 * STW - 1) ? DP : SP;
        if (ns >= tgt && ns >= m_score[1-t] + MG) begin
          m_ha[m_setno-1] = (t == 0) ? ns : m_score[0];
          m_hb[m_setno-1] = (t == 1) ? ns : m_score[1];
          m_nhist++;
          m_sets[t]++;
          m_score[0] = 0; m_score[1] = 0;
          m_uvld = 0; m_done = 1;
          m_server = m_setno % 2;
          if (m_sets[t] == STW) begin m_over = 1; m_winner = t; end
          else m_setno++;
        end else begin
          m_score[t] = ns; m_server = t; m_last = t; m_uvld = 1;
        end
      end
    end
  endfunction

  task automatic compare_all();
    check("score_a", int'(score_a), m_score[0]);
    check("score_b", int'(score_b), m_score[1]);
    check("sets_a", int'(sets_a), m_sets[0]);
    check("sets_b", int'(sets_b), m_sets[1]);
    check("set_no", int'(set_no), m_setno);
    check("server", int'(server), m_server);
    check("set_done", int'(set_done), m_done);
    check("match_over", int'(match_over), m_over);
    check("winner", int'(winner), m_winner);
    check("err", int'(err), m_err);
    check("hist_vld", int'(hist_vld), (int'(hist_idx) < m_nhist) ? 1 : 0);
    if (int'(hist_idx) < m_nhist) begin
      check("hist_a", int'(hist_a), m_ha[hist_idx]);
      check("hist_b", int'(hist_b), m_hb[hist_idx]);
    end
  endtask

  task automatic step(input bit pa, input bit pb, input bit un, input bit nm);
    point_a = pa; point_b = pb; undo = un; new_match = nm;
    @(negedge iCLK);
    point_a = 0; point_b = 0; undo = 0; new_match = 0;
    model_step(pa, pb, un, nm);
    compare_all();
    n_txn++;
    $display("txn %0d a=%0b b=%0b u=%0b n=%0b -> %0d:%0d sets %0d-%0d set %0d done=%0b err=%0b",
             n_txn, pa, pb, un, nm, score_a, score_b, sets_a, sets_b, set_no, set_done, err);
  endtask

  task automatic async_reset_main();
    #2 iRST_N = 1'b0;
    #1 model_clear();
    compare_all();
    $display("txn async reset (main)");
    @(negedge iCLK);
    iRST_N = 1'b1;
  endtask

  task automatic s_step(input bit pa);
    s_pa = pa;
    @(negedge iCLK);
    s_pa = 0;
    n_txn++;
    $display("txn %0d sat a=%0b -> %0d:%0d err=%0b", n_txn, pa, s_score_a, s_score_b, s_err);
  endtask

  initial begin
    int r;
    model_clear();
    #12 compare_all();
    @(negedge iCLK);
    iRST_N = 1'b1; s_rst_n = 1'b1;

    // Straight 25-0 set
    repeat (25) step(1, 0, 0, 0);
    check("t1_done", int'(set_done), 1);
    check("t1_sets_a", int'(sets_a), 1);
    check("t1_set_no", int'(set_no), 2);
    check("t1_hist_a", int'(hist_a), 25);
    check("t1_hist_b", int'(hist_b), 0);
    step(0, 0, 0, 0);

    // Deuce: 24:24 then A,B,A,A closes at 27:25
    step(0, 0, 0, 1);
    for (int i = 0; i < 24; i++) begin step(1, 0, 0, 0); step(0, 1, 0, 0); end
    step(1, 0, 0, 0); check("t2_open_25_24", int'(set_done), 0);
    step(0, 1, 0, 0);
    step(1, 0, 0, 0); check("t2_open_26_25", int'(set_done), 0);
    step(1, 0, 0, 0); check("t2_close", int'(set_done), 1);
    check("t2_hist_a", int'(hist_a), 27);
    check("t2_hist_b", int'(hist_b), 25);

    // Sets 2-2, then the 15-point decider to B
    step(0, 0, 0, 1);
    for (int s = 0; s < 4; s++) repeat (25) step(s % 2 == 0, s % 2 == 1, 0, 0);
    check("t3_set_no", int'(set_no), 5);
    repeat (15) step(0, 1, 0, 0);
    check("t3_over", int'(match_over), 1);
    check("t3_winner", int'(winner), 1);
    check("t3_sets_b", int'(sets_b), 3);
    step(1, 0, 0, 0); check("t3_over_err", int'(err), 1);
    step(0, 0, 1, 0);

    // Undo and simultaneous points
    step(0, 0, 0, 1);
    step(1, 0, 0, 0); step(0, 0, 1, 0);
    check("t4_undo", int'(score_a), 0);
    step(0, 0, 1, 0); check("t4_undo2_err", int'(err), 1);
    step(1, 1, 0, 0); check("t4_both_err", int'(err), 1);

    // Undo straight after closure
    step(0, 0, 0, 1);
    repeat (25) step(1, 0, 0, 0);
    step(0, 0, 1, 0); check("t5_undo_err", int'(err), 1);
    check("t5_hist_a", int'(hist_a), 25);

    // Narrow score: saturation, then async clear mid-set
    repeat (7) s_step(1);
    check("t6_sat", int'(s_score_a), 7);
    s_step(1);
    check("t6_sat_err", int'(s_err), 1);
    check("t6_sat_hold", int'(s_score_a), 7);
    #2 s_rst_n = 1'b0;
    #1 check("t6_async_clr", int'(s_score_a), 0);
    check("t6_async_err", int'(s_err), 0);
    @(negedge iCLK);
    s_rst_n = 1'b1;

    // Main instance: async clear in the middle of a set
    repeat (5) step(0, 1, 0, 0);
    async_reset_main();

    // Random play
    for (int n = 0; n < 1500; n++) begin
      hist_idx = 3'($urandom_range(7, 0));
      r = int'($urandom_range(999, 0));
      if (n == 700) async_reset_main();
      else if (m_over != 0 && $urandom_range(9, 0) == 0) step(0, 0, 0, 1);
      else if (r < 440) step(1, 0, 0, 0);
      else if (r < 880) step(0, 1, 0, 0);
      else if (r < 950) step(0, 0, 1, 0);
      else if (r < 970) step(1, 1, 0, 0);
      else if (r < 975) step(0, 0, 0, 1);
      else if (r < 985) step(r[0], ~r[0], 1, 0);
      else step(0, 0, 0, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
